// File: rtl/lsu_arbiter_16b.sv
// Two-port arbiter/sequencer in front of the 16-bit LSU request port.
// Data port has priority; a starvation counter guarantees fetch progress.
module lsu_arbiter_16b #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        a_rst,
  input  logic        p0_req,
  input  logic [15:0] p0_addr,
  input  logic        p0_width,
  output logic        p0_ack,
  output logic        p0_done,
  input  logic        p1_req,
  input  logic [15:0] p1_addr,
  input  logic        p1_wr_addr,
  input  logic [15:0] p1_data,
  input  logic        p1_width,
  input  logic        p1_cmd,
  output logic        p1_ack,
  output logic        p1_done,
  output logic [15:0] lsu_rq_addr,
  output logic        lsu_rq_wr_addr,
  output logic [15:0] lsu_rq_data,
  output logic        lsu_rq_width,
  output logic        lsu_rq_cmd,
  output logic        lsu_rq_t_id,
  output logic        lsu_rq_start,
  input  logic        lsu_rq_ack,
  input  logic        lsu_t_id,
  input  logic        mem_rdy,
  output logic        owner,
  output logic        busy
);

  // state | meaning
  // IDLE  | no transaction, grant and capture a request
  // ISSUE | rq_start asserted from hold registers until LSU accepts
  // WAIT  | waiting for mem_rdy tagged with the owner's transaction ID

  // A limit of 0 still needs a 1-bit counter; it simply never leaves 0.
  localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] starve_cnt;
  logic          gnt0, gnt1, done_hit;
  logic [15:0]   hold_addr, hold_data;
  logic          hold_wr_addr, hold_width, hold_cmd;
  logic          owner_q, p0_done_q, p1_done_q;

  always_comb begin
    gnt1      = p1_req & (~p0_req | (starve_cnt != LIMIT));
    gnt0      = p0_req & ~gnt1;
    done_hit  = (state == WAIT) & mem_rdy & (lsu_t_id == owner_q);
    state_nxt = state;
    case (state)
      IDLE:    if (gnt0 | gnt1) state_nxt = ISSUE;
      ISSUE:   if (lsu_rq_ack)  state_nxt = WAIT;
      WAIT:    if (done_hit)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (gnt1 && p0_req) begin
        if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + CW'(1);
      end else if (gnt0 || gnt1) begin
        starve_cnt <= '0;
      end
    end
  end

  // Fetch carries no data and always reloads its address as a read.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      hold_addr    <= '0;
      hold_data    <= '0;
      hold_wr_addr <= 1'b0;
      hold_width   <= 1'b0;
      hold_cmd     <= 1'b0;
      owner_q      <= 1'b0;
    end else if (state == IDLE) begin
      if (gnt1) begin
        hold_addr    <= p1_addr;
        hold_data    <= p1_data;
        hold_wr_addr <= p1_wr_addr;
        hold_width   <= p1_width;
        hold_cmd     <= p1_cmd;
        owner_q      <= 1'b1;
      end else if (gnt0) begin
        hold_addr    <= p0_addr;
        hold_data    <= '0;
        hold_wr_addr <= 1'b1;
        hold_width   <= p0_width;
        hold_cmd     <= 1'b0;
        owner_q      <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      p0_done_q <= 1'b0;
      p1_done_q <= 1'b0;
    end else begin
      p0_done_q <= done_hit & ~owner_q;
      p1_done_q <= done_hit & owner_q;
    end
  end

  assign p0_ack         = (state == IDLE) & gnt0;
  assign p1_ack         = (state == IDLE) & gnt1;
  assign p0_done        = p0_done_q;
  assign p1_done        = p1_done_q;
  assign lsu_rq_addr    = hold_addr;
  assign lsu_rq_wr_addr = hold_wr_addr;
  assign lsu_rq_data    = hold_data;
  assign lsu_rq_width   = hold_width;
  assign lsu_rq_cmd     = hold_cmd;
  assign lsu_rq_t_id    = owner_q;
  assign lsu_rq_start   = (state == ISSUE);
  assign owner          = owner_q;
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_lsu_arbiter_16b.sv
// Scoreboard bench for lsu_arbiter_16b: expected LSU requests and done
// pulses are queued when stimulus is driven and popped when the DUT emits them.
module tb_lsu_arbiter_16b;

  logic        clk = 1'b0;
  logic        a_rst;
  logic        p0_req, p0_width, p0_ack, p0_done;
  logic [15:0] p0_addr;
  logic        p1_req, p1_wr_addr, p1_width, p1_cmd, p1_ack, p1_done;
  logic [15:0] p1_addr, p1_data;
  logic [15:0] lsu_rq_addr, lsu_rq_data;
  logic        lsu_rq_wr_addr, lsu_rq_width, lsu_rq_cmd, lsu_rq_t_id, lsu_rq_start;
  logic        lsu_rq_ack, lsu_t_id, mem_rdy, owner, busy;

  typedef struct packed {
    logic        t_id;
    logic [15:0] addr;
    logic        wr_addr;
    logic [15:0] data;
    logic        width;
    logic        cmd;
  } rq_t;

  rq_t  rq_q[$];
  bit   done_q[$];
  rq_t  exp_rq, obs_rq;
  bit   start_prev = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  logic [42:0] outs;
  assign outs = {p0_ack, p0_done, p1_ack, p1_done, lsu_rq_addr, lsu_rq_wr_addr,
                 lsu_rq_data, lsu_rq_width, lsu_rq_cmd, lsu_rq_t_id, lsu_rq_start,
                 owner, busy};

  lsu_arbiter_16b #(.STARVE_LIMIT(3)) dut (
    .clk(clk), .a_rst(a_rst),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_width(p0_width),
    .p0_ack(p0_ack), .p0_done(p0_done),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_wr_addr(p1_wr_addr),
    .p1_data(p1_data), .p1_width(p1_width), .p1_cmd(p1_cmd),
    .p1_ack(p1_ack), .p1_done(p1_done),
    .lsu_rq_addr(lsu_rq_addr), .lsu_rq_wr_addr(lsu_rq_wr_addr),
    .lsu_rq_data(lsu_rq_data), .lsu_rq_width(lsu_rq_width),
    .lsu_rq_cmd(lsu_rq_cmd), .lsu_rq_t_id(lsu_rq_t_id),
    .lsu_rq_start(lsu_rq_start), .lsu_rq_ack(lsu_rq_ack),
    .lsu_t_id(lsu_t_id), .mem_rdy(mem_rdy), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic rq_t mk_rq(input bit port, input logic [15:0] addr, input logic [15:0] data,
                                input bit wr_addr, input bit width, input bit cmd);
    rq_t r;
    r.t_id    = port;
    r.addr    = addr;
    r.wr_addr = port ? wr_addr : 1'b1;
    r.data    = port ? data : 16'h0000;
    r.width   = width;
    r.cmd     = port ? cmd : 1'b0;
    return r;
  endfunction

  // Output monitor: pops the scoreboard when the DUT emits a request or done.
  always @(negedge clk) begin
    obs_rq = {lsu_rq_t_id, lsu_rq_addr, lsu_rq_wr_addr, lsu_rq_data, lsu_rq_width, lsu_rq_cmd};
    if (lsu_rq_start && !start_prev) begin
      if (rq_q.size() == 0) chk("rq_unexp", 64'(lsu_rq_start), 64'(0));
      else begin
        exp_rq = rq_q.pop_front();
        chk("rq_fields", 64'(obs_rq), 64'(exp_rq));
      end
    end else if (lsu_rq_start) begin
      chk("rq_stable", 64'(obs_rq), 64'(exp_rq));
    end
    start_prev = lsu_rq_start;
    if (p0_done || p1_done) begin
      if (done_q.size() == 0) chk("done_unexp", 64'({p1_done, p0_done}), 64'(0));
      else chk("done_port", 64'({p1_done, p0_done}), done_q.pop_front() ? 64'(2) : 64'(1));
    end
  end

  task automatic drive_req(input bit port, input logic [15:0] addr, input logic [15:0] data,
                           input bit wr_addr, input bit width, input bit cmd);
    if (port) begin
      p1_req = 1'b1; p1_addr = addr; p1_data = data;
      p1_wr_addr = wr_addr; p1_width = width; p1_cmd = cmd;
    end else begin
      p0_req = 1'b1; p0_addr = addr; p0_width = width;
      p1_data = data; p1_cmd = cmd;
    end
  endtask

  // One complete transaction; LSU withholds rq_ack for bp cycles, mem_rdy
  // follows after wcyc idle WAIT cycles, optionally preceded by a wrong-tag strobe.
  task automatic txn(input bit port, input logic [15:0] addr, input logic [15:0] data,
                     input bit wr_addr, input bit width, input bit cmd,
                     input int bp, input int wcyc, input bit bad_tid);
    drive_req(port, addr, data, wr_addr, width, cmd);
    rq_q.push_back(mk_rq(port, addr, data, wr_addr, width, cmd));
    done_q.push_back(port);
    #1 chk("ack", 64'({p1_ack, p0_ack}), port ? 64'(2) : 64'(1));
    @(posedge clk); #1;
    p0_req = 1'b0; p1_req = 1'b0;
    for (int i = 0; i <= bp; i++) begin
      lsu_rq_ack = (i == bp);
      mem_rdy = 1'b1; lsu_t_id = port;
      #1 chk("issue_start", 64'(lsu_rq_start), 64'(1));
      @(posedge clk); #1;
    end
    lsu_rq_ack = 1'b0; mem_rdy = 1'b0;
    #1 chk("wait_state", 64'({lsu_rq_start, busy, owner}), 64'({1'b0, 1'b1, port}));
    for (int i = 0; i < wcyc; i++) begin
      @(posedge clk); #1;
    end
    if (bad_tid) begin
      mem_rdy = 1'b1; lsu_t_id = ~port;
      @(posedge clk); #1 mem_rdy = 1'b0;
      #1 chk("bad_tid_hold", 64'({busy, p1_done, p0_done}), 64'(3'b100));
    end
    mem_rdy = 1'b1; lsu_t_id = port;
    @(posedge clk); #1 mem_rdy = 1'b0;
    #1 chk("done", 64'({p1_done, p0_done, busy}), port ? 64'(3'b100) : 64'(3'b010));
    @(posedge clk); #1;
    #1 chk("done_pulse_end", 64'({p1_done, p0_done}), 64'(0));
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2 a_rst = 1'b1;
    #1 chk("reset_outs", 64'(outs), 64'(0));
    rq_q.delete(); done_q.delete();
    #1 a_rst = 1'b0;
  endtask

  bit gnt_seq[8]  = '{1, 1, 1, 0, 1, 1, 1, 0};
  int cnt_seq[8]  = '{1, 2, 3, 0, 1, 2, 3, 0};

  initial begin
    a_rst = 1'b1;
    p0_req = 0; p0_addr = 0; p0_width = 0;
    p1_req = 0; p1_addr = 0; p1_wr_addr = 0; p1_data = 0; p1_width = 0; p1_cmd = 0;
    lsu_rq_ack = 0; lsu_t_id = 0; mem_rdy = 0;
    #2 chk("reset_outs", 64'(outs), 64'(0));
    repeat (2) @(posedge clk);
    #1 a_rst = 1'b0;
    @(posedge clk); #1;

    txn(0, 16'h1234, 16'hBEEF, 1'b0, 1'b1, 1'b1, 0, 2, 1'b0);
    txn(1, 16'h0101, 16'hBEEF, 1'b1, 1'b0, 1'b1, 3, 0, 1'b0);
    txn(1, 16'h5A5A, 16'h0F0F, 1'b0, 1'b1, 1'b0, 1, 1, 1'b0);
    txn(0, 16'h4000, 16'h0000, 1'b1, 1'b0, 1'b0, 0, 1, 1'b1);
    txn(1, 16'hFFFF, 16'h1357, 1'b1, 1'b1, 1'b1, 0, 0, 1'b1);

    // Reset during ISSUE
    @(posedge clk); #1;
    drive_req(1, 16'h2222, 16'h3333, 1'b1, 1'b1, 1'b1);
    rq_q.push_back(mk_rq(1, 16'h2222, 16'h3333, 1'b1, 1'b1, 1'b1));
    @(posedge clk); #1 p1_req = 1'b0;
    #1 chk("issue_before_rst", 64'(lsu_rq_start), 64'(1));
    #5 a_rst = 1'b1;
    #1 chk("rst_in_issue", 64'(outs), 64'(0));
    #1 a_rst = 1'b0;

    // Reset during WAIT; a late mem_rdy must not produce a done pulse
    @(posedge clk); #1;
    drive_req(0, 16'h7777, 16'h0000, 1'b1, 1'b1, 1'b0);
    rq_q.push_back(mk_rq(0, 16'h7777, 16'h0000, 1'b1, 1'b1, 1'b0));
    @(posedge clk); #1 p0_req = 1'b0; lsu_rq_ack = 1'b1;
    @(posedge clk); #1 lsu_rq_ack = 1'b0;
    #1 chk("wait_before_rst", 64'({busy, lsu_rq_start}), 64'(2'b10));
    a_rst = 1'b1;
    #1 chk("rst_in_wait", 64'(outs), 64'(0));
    #1 a_rst = 1'b0;
    mem_rdy = 1'b1; lsu_t_id = 1'b0;
    repeat (2) @(posedge clk);
    #1 mem_rdy = 1'b0;
    #1 chk("idle_after_rst", 64'({busy, p1_done, p0_done}), 64'(0));
    @(posedge clk); #1;
    txn(0, 16'h0042, 16'h0000, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);

    // Both ports request continuously: starvation limit forces every 4th grant to fetch
    pulse_reset();
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      drive_req(1, 16'h2000 + 16'(k), 16'hA000 + 16'(k), 1'b1, 1'b1, 1'b1);
      drive_req(0, 16'h1000 + 16'(k), 16'hA000 + 16'(k), 1'b1, 1'b0, 1'b1);
      rq_q.push_back(gnt_seq[k] ? mk_rq(1, 16'h2000 + 16'(k), 16'hA000 + 16'(k), 1'b1, 1'b1, 1'b1)
                                : mk_rq(0, 16'h1000 + 16'(k), 16'h0000, 1'b1, 1'b0, 1'b0));
      done_q.push_back(gnt_seq[k]);
      #1 chk("starve_ack", 64'({p1_ack, p0_ack}), gnt_seq[k] ? 64'(2) : 64'(1));
      if (k > 0)
        chk("done_with_ack", 64'({p1_done, p0_done}), gnt_seq[k-1] ? 64'(2) : 64'(1));
      @(posedge clk); #1 lsu_rq_ack = 1'b1;
      #1 chk("starve_cnt", 64'(dut.starve_cnt), 64'(cnt_seq[k]));
      @(posedge clk); #1 lsu_rq_ack = 1'b0; mem_rdy = 1'b1; lsu_t_id = gnt_seq[k];
      @(posedge clk); #1 mem_rdy = 1'b0;
    end
    p0_req = 1'b0; p1_req = 1'b0;
    #1 chk("starve_last_done", 64'({p1_done, p0_done, busy}), 64'(3'b010));
    repeat (3) @(posedge clk);
    #1 chk("queues_drained", 64'(rq_q.size() + done_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule

// File: doc/lsu_arbiter_16b.md
Name: lsu_arbiter_16b

Overview:
- Two-port arbiter and sequencer in front of the 16-bit load/store unit request port.
- Shares the LSU between the instruction-fetch port (port 0, read-only) and the data port (port 1, read/write).
- Tags each transaction with the requester index as the LSU transaction ID, holds the request stable until the LSU accepts it, then waits for the tagged completion and routes a done pulse back to the owner.
- Data port has priority; a starvation counter guarantees fetch progress.

Parameters:
- STARVE_LIMIT, 3, max consecutive data-port grants while fetch is waiting; 0 means fetch always wins a tie.

Ports:
- clk  in  1  clock, rising edge
- a_rst  in  1  asynchronous active-high reset
- p0_req  in  1  fetch request, held until p0_ack
- p0_addr  in  16  fetch address
- p0_width  in  1  0=byte, 1=word
- p0_ack  out  1  fetch request captured this cycle
- p0_done  out  1  fetch transaction complete, one-cycle pulse
- p1_req  in  1  data request, held until p1_ack
- p1_addr  in  16  data address
- p1_wr_addr  in  1  1=load new address into LSU, 0=reuse LSU address
- p1_data  in  16  write data
- p1_width  in  1  0=byte, 1=word
- p1_cmd  in  1  0=read, 1=write
- p1_ack  out  1  data request captured this cycle
- p1_done  out  1  data transaction complete, one-cycle pulse
- lsu_rq_addr  out  16  to LSU rq_addr
- lsu_rq_wr_addr  out  1  to LSU rq_wr_addr
- lsu_rq_data  out  16  to LSU rq_data
- lsu_rq_width  out  1  to LSU rq_width
- lsu_rq_cmd  out  1  to LSU rq_cmd
- lsu_rq_t_id  out  1  to LSU rq_t_id; equals owner index
- lsu_rq_start  out  1  to LSU rq_start
- lsu_rq_ack  in  1  from LSU rq_ack
- lsu_t_id  in  1  from LSU t_id
- mem_rdy  in  1  memory completion strobe for the current bus transaction
- owner  out  1  index of the port holding the LSU; valid when busy=1
- busy  out  1  arbiter not IDLE

Behaviour:
- Reset (async, a_rst=1): state=IDLE. All hold registers, owner, and the starvation counter are 0. All outputs are 0.
- Reset mid-transaction drops the transaction. No done pulse is issued.
- State machine: IDLE, ISSUE, WAIT.
- IDLE, grant selection:
  - Only one req asserted: that port wins.
  - Both asserted: port 1 wins unless starve_cnt == STARVE_LIMIT, in which case port 0 wins.
- IDLE, capture:
  - pX_ack is combinational (state==IDLE & granted X), so the requester sees ack in its request cycle.
  - At the same edge, latch the fields into hold registers, set owner=X, and go to ISSUE.
  - Port 0 is latched as wr_addr=1, cmd=0, data=0.
- Starvation counter:
  - Width $clog2(STARVE_LIMIT+1).
  - On a port-1 grant with p0_req=1: increments, saturating at STARVE_LIMIT.
  - On a port-0 grant, or a port-1 grant with p0_req=0: cleared.
- ISSUE: lsu_rq_start=1 and lsu_rq_* driven from the hold registers, stable every cycle. When lsu_rq_ack=1, go to WAIT at the next edge.
- WAIT:
  - lsu_rq_start=0.
  - When mem_rdy=1 and lsu_t_id==owner: the registered p{owner}_done is 1 for exactly the next cycle, and state returns to IDLE.
  - mem_rdy with mismatched lsu_t_id is ignored.
- mem_rdy in IDLE or ISSUE is ignored.
- A done pulse and a new ack may occur in the same cycle.
- Outside ISSUE, lsu_rq_* hold their last values; they are only meaningful while lsu_rq_start=1.
- Latency with zero LSU backpressure:
  - req at cycle 0: ack at cycle 0, start at cycle 1, WAIT from cycle 2.
  - mem_rdy at cycle n gives done and IDLE at cycle n+1.
- Requests deasserted while not acked are simply not served. There is no internal queue.

Test Plan:
- Fetch only, addr 0x1234, width 1: p0_ack at cycle 0; lsu_rq_start=1 at cycle 1 with addr 0x1234, cmd 0, wr_addr 1, t_id 0; lsu_rq_ack at cycle 1; mem_rdy with t_id 0 at cycle 4 -> p0_done=1 at cycle 5 only, busy=0 at cycle 5.
- Data write, addr 0x0101, data 0xBEEF, cmd 1, width 0; LSU withholds lsu_rq_ack for 3 cycles -> lsu_rq_start and all fields held stable for 4 cycles; t_id 1; p1_done after the tagged mem_rdy.
- Both ports request continuously, STARVE_LIMIT=3 -> grant order 1,1,1,0,1,1,1,0; starve_cnt sequence 1,2,3,0.
- In WAIT, mem_rdy with lsu_t_id=1 while owner=0 -> no done and state stays WAIT; a later mem_rdy with t_id 0 -> p0_done.
- Assert a_rst during ISSUE and during WAIT -> all outputs 0 immediately, no done pulse; the next request after release is served normally.
- Completion cycle with p1_req asserted -> p0_done and p1_ack both 1 in the same cycle; the new transaction proceeds.
